// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: captures BCD digits on load and scans them
// onto one shared segment bus, with leading-zero blanking, blink and a frame tick.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 4,
  parameter int BLINK_DIV      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        dig_idx;
  logic [FRAME_W-1:0]      frame_cnt;
  logic                    blink_phase;
  logic                    first_sel;

  logic                    scan_wrap, dig_wrap, frame_wrap;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  assign scan_wrap  = (scan_cnt  == SCAN_W'(SCAN_DIV - 1));
  assign dig_wrap   = (dig_idx   == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = (frame_cnt == FRAME_W'(BLINK_DIV - 1));

  // zero_from[i]: every nibble at position i and above is zero
  always_comb begin
    zero_from = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      for (int unsigned j = i; j < NUM_DIGITS; j++) begin
        if (shadow[4*j +: 4] != 4'd0) zero_from[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    sel_nxt   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nib    = shadow[4*i +: 4];
        cur_blank  = (i > 0) && blank_lz && zero_from[i];
        sel_nxt[i] = 1'b1;
      end
    end
    case (cur_nib)
      4'd0:    seg_nxt = 7'h3F;
      4'd1:    seg_nxt = 7'h06;
      4'd2:    seg_nxt = 7'h5B;
      4'd3:    seg_nxt = 7'h4F;
      4'd4:    seg_nxt = 7'h66;
      4'd5:    seg_nxt = 7'h6D;
      4'd6:    seg_nxt = 7'h7D;
      4'd7:    seg_nxt = 7'h07;
      4'd8:    seg_nxt = 7'h7F;
      4'd9:    seg_nxt = 7'h6F;
      default: seg_nxt = 7'h00;
    endcase
    if (cur_blank || (blink_en && !blink_phase)) seg_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow      <= '0;
      scan_cnt    <= '0;
      dig_idx     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      first_sel   <= 1'b1;
      frame_tick  <= 1'b0;
      seg_out     <= {7{SEG_ACTIVE_LOW}};
      dig_sel     <= {NUM_DIGITS{SEG_ACTIVE_LOW}};
    end else begin
      if (load) shadow <= digits_in;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        dig_idx <= dig_wrap ? '0 : dig_idx + 1'b1;
        if (dig_wrap) begin
          frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
          if (frame_wrap) blink_phase <= ~blink_phase;
        end
      end
      // Outputs reflect the pre-edge state; the selection at scan start is
      // the moment dig_sel lands on digit 0, except right after reset.
      first_sel  <= 1'b0;
      frame_tick <= !first_sel && (scan_cnt == '0) && (dig_idx == '0);
      seg_out    <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      dig_sel    <= sel_nxt ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver; the reference model derives
// expected outputs from elapsed clocks since reset and the captured digits.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] digits_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg_out;
  logic [2:0]  dig_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(3),
    .SCAN_DIV(4),
    .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits_in(digits_in),
    .load(load),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg_out(seg_out),
    .dig_sel(dig_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model state: clocks elapsed since reset release, captured digits
  int          t_model = 0;
  logic [11:0] m_shadow = '0;
  logic [6:0]  exp_seg;
  logic [2:0]  exp_sel;
  logic        exp_tick;
  logic [6:0]  seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Predict the outputs of the coming edge, advance the model, then clock.
  task automatic step();
    int d;
    logic [3:0] nib;
    if (!rst_n) begin
      exp_seg = '0; exp_sel = '0; exp_tick = 1'b0;
      t_model = 0; m_shadow = '0;
    end else begin
      d        = (t_model / 4) % 3;
      nib      = m_shadow[4*d +: 4];
      exp_seg  = (nib < 10) ? seg_tbl[nib] : 7'h00;
      if (blank_lz && d > 0 && (m_shadow >> (4*d)) == 12'd0) exp_seg = 7'h00;
      if (blink_en && ((t_model / 24) % 2) == 1) exp_seg = 7'h00;
      exp_sel  = 3'b001 << d;
      exp_tick = (t_model > 0) && (t_model % 12 == 0);
      t_model++;
      if (load) m_shadow = digits_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (seg_out !== 7'h00 || dig_sel !== 3'b000 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: seg=%h sel=%b tick=%b required seg=00 sel=000 tick=0",
                 seg_out, dig_sel, frame_tick);
      end
    end
    rst_n = 1'b1; digits_in = 12'h000;
    step();
    checks++;
    if (dig_sel !== 3'b001 || seg_out !== 7'h3F || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_sel: seg=%h sel=%b tick=%b required seg=3f sel=001 tick=0",
               seg_out, dig_sel, frame_tick);
    end
    repeat (16) begin
      step();
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_scan t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
    end
  endtask

  task automatic test_decode();
    int last_tick = -1;
    int cyc = 0;
    digits_in = 12'h259; load = 1'b1;
    step();
    load = 1'b0;
    repeat (40) begin
      step();
      cyc++;
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL decode t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (cyc - last_tick != 12) begin
            errors++;
            $display("FAIL tick_period: got %0d clks required 12", cyc - last_tick);
          end
        end
        last_tick = cyc;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] pats [3] = '{12'h005, 12'h000, 12'h100};
    blank_lz = 1'b1;
    foreach (pats[p]) begin
      digits_in = pats[p]; load = 1'b1;
      step();
      load = 1'b0;
      repeat (14) begin
        step();
        checks++;
        if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
          errors++;
          $display("FAIL lz_%h t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                   pats[p], t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    digits_in = 12'h123; load = 1'b1;
    step();
    load = 1'b0; blink_en = 1'b1;
    repeat (60) begin
      step();
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL blink t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_invalid();
    digits_in = 12'hA9F; load = 1'b1;
    step();
    load = 1'b0;
    repeat (14) begin
      step();
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL invalid t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    repeat (500) begin
      digits_in = 12'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in[3:0] = 4'd0;
      if ($urandom_range(0, 1) == 0) digits_in[11:4] = 8'd0;
      load     = ($urandom_range(0, 3) == 0);
      blank_lz = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      step();
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL random t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
    end
    load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int budget = 200;
    digits_in = 12'h321; load = 1'b1;
    step();
    load = 1'b0; blink_en = 1'b1;
    while (!(((t_model / 24) % 2) == 1 && ((t_model / 4) % 3) == 1 && (t_model % 4) == 2)
           && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL mid_reset_seek: no off-phase digit-1 slot within 200 clks");
    end
    checks++;
    if (dig_sel !== 3'b010 || seg_out !== 7'h00) begin
      errors++;
      $display("FAIL mid_reset_pre: seg=%h sel=%b required seg=00 sel=010", seg_out, dig_sel);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (seg_out !== 7'h00 || dig_sel !== 3'b000 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_off: seg=%h sel=%b tick=%b required seg=00 sel=000 tick=0",
               seg_out, dig_sel, frame_tick);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (dig_sel !== 3'b001 || seg_out !== 7'h3F || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_restart: seg=%h sel=%b tick=%b required seg=3f sel=001 tick=0",
               seg_out, dig_sel, frame_tick);
    end
    repeat (30) begin
      step();
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_sel || frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL mid_reset_scan t=%0d: seg=%h sel=%b tick=%b required seg=%h sel=%b tick=%b",
                 t_model, seg_out, dig_sel, frame_tick, exp_seg, exp_sel, exp_tick);
      end
    end
    blink_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_leading_zero();
    test_blink();
    test_invalid();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
